sm_regdump_uart: RTL and testbench



---
 rtl/sm_regdump_uart.sv | 152 +++++++++++++++
 tb/tb_sm_regdump_uart.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sm_regdump_uart.sv
// Debug register dumper for schoolMIPS: walks regAddr 0..31 and sends each value
// as 8 uppercase hex digits plus CR LF over a UART 8N1 line.
module sm_regdump_uart #(
    parameter int unsigned BAUD_DIV = 434
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic [4:0]  regAddr,
    input  logic [31:0] regData,
    output logic        tx,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SEND
    } state_t;

    state_t      r_state,   w_stateNext;
    logic [4:0]  r_regAddr, w_regAddrNext;
    logic [31:0] r_data,    w_dataNext;
    logic [15:0] r_baudCnt, w_baudCntNext;
    logic [3:0]  r_bitCnt,  w_bitCntNext;
    logic [3:0]  r_charCnt, w_charCntNext;
    logic        r_tx,      w_txNext;
    logic        r_busy,    w_busyNext;
    logic        r_done,    w_doneNext;

    logic [31:0] w_shifted;
    logic [3:0]  w_nibble;
    logic [7:0]  w_char;
    logic        w_baudEnd;

    // Character 0 is the most significant nibble, so shift it to the top.
    assign w_shifted = r_data << {r_charCnt, 2'b00};
    assign w_nibble  = w_shifted[31:28];
    assign w_baudEnd = (r_baudCnt == 16'(BAUD_DIV - 1));

    always_comb begin
        if (r_charCnt == 4'd8) begin
            w_char = 8'h0D;
        end else if (r_charCnt == 4'd9) begin
            w_char = 8'h0A;
        end else if (w_nibble < 4'd10) begin
            w_char = 8'h30 + {4'h0, w_nibble};
        end else begin
            w_char = 8'h37 + {4'h0, w_nibble};
        end
    end

    always_comb begin
        w_stateNext   = r_state;
        w_regAddrNext = r_regAddr;
        w_dataNext    = r_data;
        w_baudCntNext = r_baudCnt;
        w_bitCntNext  = r_bitCnt;
        w_charCntNext = r_charCnt;
        w_txNext      = r_tx;
        w_busyNext    = r_busy;
        w_doneNext    = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_txNext = 1'b1;
                if (start) begin
                    w_stateNext   = ST_LOAD;
                    w_regAddrNext = 5'd0;
                    w_busyNext    = 1'b1;
                end
            end

            ST_LOAD: begin
                w_dataNext    = regData;
                w_charCntNext = 4'd0;
                w_bitCntNext  = 4'd0;
                w_baudCntNext = 16'd0;
                w_txNext      = 1'b0;
                w_stateNext   = ST_SEND;
            end

            ST_SEND: begin
                if (!w_baudEnd) begin
                    w_baudCntNext = r_baudCnt + 16'd1;
                end else begin
                    w_baudCntNext = 16'd0;
                    if (r_bitCnt != 4'd9) begin
                        // tx is registered, so it is loaded with the bit about to start.
                        w_bitCntNext = r_bitCnt + 4'd1;
                        w_txNext     = (r_bitCnt == 4'd8) ? 1'b1 : w_char[r_bitCnt[2:0]];
                    end else begin
                        w_bitCntNext = 4'd0;
                        if (r_charCnt != 4'd9) begin
                            w_charCntNext = r_charCnt + 4'd1;
                            w_txNext      = 1'b0;
                        end else begin
                            w_charCntNext = 4'd0;
                            w_txNext      = 1'b1;
                            if (r_regAddr != 5'd31) begin
                                w_regAddrNext = r_regAddr + 5'd1;
                                w_stateNext   = ST_LOAD;
                            end else begin
                                w_regAddrNext = 5'd0;
                                w_busyNext    = 1'b0;
                                w_doneNext    = 1'b1;
                                w_stateNext   = ST_IDLE;
                            end
                        end
                    end
                end
            end

            default: begin
                w_stateNext = ST_IDLE;
                w_txNext    = 1'b1;
                w_busyNext  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_regAddr <= 5'd0;
            r_data    <= 32'd0;
            r_baudCnt <= 16'd0;
            r_bitCnt  <= 4'd0;
            r_charCnt <= 4'd0;
            r_tx      <= 1'b1;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_stateNext;
            r_regAddr <= w_regAddrNext;
            r_data    <= w_dataNext;
            r_baudCnt <= w_baudCntNext;
            r_bitCnt  <= w_bitCntNext;
            r_charCnt <= w_charCntNext;
            r_tx      <= w_txNext;
            r_busy    <= w_busyNext;
            r_done    <= w_doneNext;
        end
    end

    assign regAddr = r_regAddr;
    assign tx      = r_tx;
    assign busy    = r_busy;
    assign done    = r_done;

endmodule

// File: tb/tb_sm_regdump_uart.sv
// Bench for sm_regdump_uart: CPU register model, UART frame decoder and a byte
// scoreboard fed with the text each dump should produce.
module tb_sm_regdump_uart;

    localparam int BAUD        = 4;
    localparam int REG_CYCLES  = 1 + 100 * BAUD;
    localparam int DUMP_CYCLES = 32 * REG_CYCLES;
    localparam int WAVE_LEN    = 2 + 10 * BAUD;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [4:0]  regAddr;
    logic [31:0] regData;
    logic        tx;
    logic        busy;
    logic        done;

    logic [31:0] regMem [32];
    logic [7:0]  expQ [$];
    string       hexDigits = "0123456789ABCDEF";

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    assign regData = regMem[regAddr];

    sm_regdump_uart #(.BAUD_DIV(BAUD)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .regAddr (regAddr),
        .regData (regData),
        .tx      (tx),
        .busy    (busy),
        .done    (done)
    );

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
        end
    endtask

    // Expected text of one dump, taken from the register model as it stands now.
    function automatic void pushDump();
        logic [31:0] word;
        logic [3:0]  nib;
        for (int a = 0; a < 32; a++) begin
            word = regMem[a];
            for (int i = 0; i < 8; i++) begin
                nib  = word[31:28];
                word = word << 4;
                expQ.push_back(8'(hexDigits[int'(nib)]));
            end
            expQ.push_back(8'h0D);
            expQ.push_back(8'h0A);
        end
    endfunction

    task automatic applyStimulus(input int dumps);
        @(posedge clk);
        #1;
        for (int d = 0; d < dumps; d++) pushDump();
        start = 1'b1;
    endtask

    task automatic waitForDone(input int maxCycles, input string name);
        int  n;
        bit  seen;
        n    = 0;
        seen = 1'b0;
        while (!seen && n < maxCycles) begin
            @(negedge clk);
            n++;
            if (done === 1'b1) seen = 1'b1;
        end
        checkOutput(name, 64'(seen), 64'd1);
    endtask

    task automatic waitForAddr(input logic [4:0] addr, input int maxCycles);
        int n;
        bit seen;
        n    = 0;
        seen = 1'b0;
        while (!seen && n < maxCycles) begin
            @(negedge clk);
            n++;
            if (regAddr === addr) seen = 1'b1;
        end
        checkOutput("reachAddr", 64'(seen), 64'd1);
    endtask

    // UART decoder, busy-length and done-placement monitor, sampled on falling edges.
    bit          decActive = 1'b0;
    int          decCnt = 0;
    logic [7:0]  decByte = 8'h00;
    logic        prevBusy = 1'b0;
    int          busyLen = 0;
    bit          abortPending = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            decActive    = 1'b0;
            expQ.delete();
            abortPending = 1'b1;
        end else if (!decActive) begin
            if (tx === 1'b0) begin
                decActive = 1'b1;
                decCnt    = 0;
            end
        end else begin
            decCnt++;
            for (int k = 0; k < 8; k++) begin
                if (decCnt == BAUD * (k + 1) + BAUD / 2) decByte[k] = tx;
            end
            if (decCnt == 9 * BAUD + BAUD / 2) begin
                decActive = 1'b0;
                checkOutput("stopBit", 64'(tx), 64'd1);
                if (expQ.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL unexpectedByte actual=0x%0h expected=none", decByte);
                end else begin
                    checkOutput("rxByte", 64'(decByte), 64'(expQ.pop_front()));
                end
            end
        end

        if (busy === 1'b1) begin
            if (prevBusy !== 1'b1) begin
                busyLen      = 0;
                abortPending = 1'b0;
            end
            busyLen++;
        end else if (prevBusy === 1'b1) begin
            if (abortPending) begin
                checkOutput("noDoneAfterReset", 64'(done), 64'd0);
            end else begin
                checkOutput("busyLength", 64'(busyLen), 64'(DUMP_CYCLES));
                checkOutput("doneOnFall", 64'(done), 64'd1);
            end
        end
        if (done === 1'b1) begin
            checkOutput("donePlacement", 64'(prevBusy === 1'b1 && busy === 1'b0), 64'd1);
        end
        prevBusy = busy;
    end

    initial begin
        logic [WAVE_LEN-1:0] cap;
        logic [WAVE_LEN-1:0] expWave;
        logic [9:0]          frame;
        logic [7:0]          firstChar;

        for (int a = 0; a < 32; a++) begin
            regMem[a] = (a == 0) ? 32'h0000_0040 : 32'hA5C3_0000 + 32'(a);
        end

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("resetTx", 64'(tx), 64'd1);
        checkOutput("resetBusy", 64'(busy), 64'd0);
        checkOutput("resetDone", 64'(done), 64'd0);
        checkOutput("resetAddr", 64'(regAddr), 64'd0);

        // Dump A: test-plan model, first-frame waveform and a late change of register 2.
        firstChar = 8'(hexDigits[int'(regMem[0][31:28])]);
        frame     = {1'b1, firstChar, 1'b0};
        expWave   = '0;
        expWave[0] = 1'b1;
        expWave[1] = 1'b1;
        for (int j = 0; j < 10; j++) begin
            for (int r = 0; r < BAUD; r++) expWave[2 + j * BAUD + r] = frame[j];
        end
        applyStimulus(1);
        @(negedge clk);
        cap[0] = tx;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int i = 1; i < WAVE_LEN; i++) begin
            @(negedge clk);
            cap[i] = tx;
        end
        checkOutput("firstFrameWave", 64'(cap), 64'(expWave));
        waitForAddr(5'd2, 3 * REG_CYCLES);
        repeat (20) @(negedge clk);
        regMem[2] = 32'hFFFF_FFFF;
        waitForDone(DUMP_CYCLES + 100, "doneA");
        regMem[2] = 32'hA5C3_0002;

        // Dump B: random register contents with start held high across the done cycle.
        for (int a = 1; a < 32; a++) regMem[a] = $urandom();
        regMem[7] = 32'h09AF_F0A9;
        regMem[8] = 32'hFFFF_FFFF;
        regMem[9] = 32'h0000_0000;
        applyStimulus(2);
        waitForDone(DUMP_CYCLES + 100, "doneB");
        checkOutput("doneCycleBusy", 64'(busy), 64'd0);
        @(negedge clk);
        checkOutput("restartBusy", 64'(busy), 64'd1);
        checkOutput("restartAddr", 64'(regAddr), 64'd0);
        @(posedge clk);
        #1;
        start = 1'b0;
        // Register 5, character 3, bit 4 begins this many cycles after the first LOAD.
        repeat (5 * REG_CYCLES + 1 + 3 * 10 * BAUD + 4 * BAUD - 1) @(negedge clk);
        checkOutput("preResetAddr", 64'(regAddr), 64'd5);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("abortTx", 64'(tx), 64'd1);
        checkOutput("abortBusy", 64'(busy), 64'd0);
        checkOutput("abortAddr", 64'(regAddr), 64'd0);
        checkOutput("abortDone", 64'(done), 64'd0);

        // Dump C: a clean dump after the aborted one.
        applyStimulus(1);
        @(posedge clk);
        #1;
        start = 1'b0;
        waitForDone(DUMP_CYCLES + 100, "doneC");
        repeat (5) @(negedge clk);
        checkOutput("queueDrained", 64'(expQ.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
